// File: rtl/key_search_arbiter_if.sv
// Handshake bundle between the key-search arbiter and its controller/cores.
// The arbiter is the slave side; the controller or testbench drives the master side.
interface key_search_arbiter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       core_done;
  logic [3:0]       core_found;
  logic [3:0]       core_start;
  logic             core_stop;
  logic [3:0]       success_state;
  logic             search_done;
  logic             search_fail;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, core_done, core_found,
    input  core_start, core_stop, success_state, search_done, search_fail, busy, cycle_count
  );

  modport slave (
    input  start, core_done, core_found,
    output core_start, core_stop, success_state, search_done, search_fail, busy, cycle_count
  );
endinterface

// File: rtl/key_search_arbiter.sv
// Launches four RC4 key-search cores, latches the lowest-index winner one-hot and stops the rest.
// All outputs registered: results appear the cycle after the deciding SEARCH cycle; start only honoured in IDLE/DONE.
module key_search_arbiter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input logic               clk,
  input logic               rst_n,
  key_search_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       start_q, start_d;
  logic             stop_q, stop_d;
  logic [3:0]       succ_q, succ_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hit;
  logic             timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= 1'b0;
      succ_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      succ_q  <= succ_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = '0;
    stop_d    = stop_q;
    succ_d    = succ_q;
    done_d    = done_q;
    fail_d    = fail_q;
    cnt_d     = cnt_q;
    hit       = bus.core_done & bus.core_found;
    timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    case (state_q)
      IDLE:   if (bus.start) state_d = LAUNCH;
      LAUNCH: state_d = ARM;
      // Cores may still show done from the previous run here, so nothing is sampled.
      ARM:    state_d = SEARCH;
      SEARCH: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (hit != 4'b0000) begin
          // Isolate the lowest set bit so simultaneous hits resolve to one winner.
          succ_d  = hit & (~hit + 4'd1);
          stop_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (bus.core_done == 4'b1111 || timed_out) begin
          fail_d  = 1'b1;
          stop_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    if (bus.start) state_d = LAUNCH;
      default: state_d = IDLE;
    endcase

    // Results are wiped as LAUNCH is entered so they read zero during the launch pulse.
    if (state_d == LAUNCH) begin
      start_d = 4'b1111;
      stop_d  = 1'b0;
      succ_d  = '0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      cnt_d   = '0;
    end
    busy_d = (state_d == LAUNCH) || (state_d == ARM) || (state_d == SEARCH);
  end

  assign bus.core_start    = start_q;
  assign bus.core_stop     = stop_q;
  assign bus.success_state = succ_q;
  assign bus.search_done   = done_q;
  assign bus.search_fail   = fail_q;
  assign bus.busy          = busy_q;
  assign bus.cycle_count   = cnt_q;

endmodule

// File: tb/tb_key_search_arbiter.sv
// Directed bench for key_search_arbiter built with TIMEOUT=20.
module tb_key_search_arbiter;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  key_search_arbiter_if #(.CNT_W(CNT_W)) bus ();

  key_search_arbiter #(.CNT_W(CNT_W), .TIMEOUT(20)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then step through LAUNCH and ARM; returns at the start of SEARCH cycle 0.
  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.core_done = 4'b0; bus.core_found = 4'b0;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({bus.core_start, bus.core_stop, bus.success_state, bus.search_done, bus.search_fail, bus.busy} !== 12'h000) $display("FAIL reset_outputs got %h want 000", {bus.core_start, bus.core_stop, bus.success_state, bus.search_done, bus.search_fail, bus.busy});
    else passed++;
    total++;
    if (bus.cycle_count !== 32'd0) $display("FAIL reset_count got %0d want 0", bus.cycle_count);
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.core_start !== 4'b1111 || bus.busy !== 1'b1) $display("FAIL launch_pulse got start=%b busy=%b want 1111/1", bus.core_start, bus.busy);
    else passed++;
    tick();
    total++;
    if (bus.core_start !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL launch_one_cycle got start=%b busy=%b want 0000/1", bus.core_start, bus.busy);
    else passed++;
    tick();
  endtask

  // Continues the run opened by test_launch: now at SEARCH cycle 0.
  task automatic test_single_hit();
    repeat (5) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.core_start !== 4'b0000 || bus.busy !== 1'b1 || bus.cycle_count !== 32'd6) $display("FAIL start_ignored got start=%b busy=%b cnt=%0d want 0000/1/6", bus.core_start, bus.busy, bus.cycle_count);
    else passed++;
    repeat (4) tick();
    bus.core_done = 4'b0100; bus.core_found = 4'b0100;
    tick();
    total++;
    if (bus.success_state !== 4'b0100 || bus.search_done !== 1'b1 || bus.core_stop !== 1'b1 || bus.search_fail !== 1'b0 || bus.busy !== 1'b0) $display("FAIL hit2_flags got succ=%b done=%b stop=%b fail=%b busy=%b want 0100/1/1/0/0", bus.success_state, bus.search_done, bus.core_stop, bus.search_fail, bus.busy);
    else passed++;
    total++;
    if (bus.cycle_count !== 32'd11) $display("FAIL hit2_count got %0d want 11", bus.cycle_count);
    else passed++;
    bus.core_done = 4'b1111; bus.core_found = 4'b0001;
    repeat (3) tick();
    total++;
    if (bus.success_state !== 4'b0100 || bus.cycle_count !== 32'd11 || bus.search_fail !== 1'b0) $display("FAIL done_hold got succ=%b cnt=%0d fail=%b want 0100/11/0", bus.success_state, bus.cycle_count, bus.search_fail);
    else passed++;
  endtask

  task automatic test_simultaneous();
    bus.core_done = 4'b0; bus.core_found = 4'b0;
    launch();
    total++;
    if ({bus.success_state, bus.search_done, bus.core_stop} !== 6'b0 || bus.cycle_count !== 32'd0) $display("FAIL relaunch_clear got succ=%b done=%b stop=%b cnt=%0d want 0/0/0/0", bus.success_state, bus.search_done, bus.core_stop, bus.cycle_count);
    else passed++;
    repeat (3) tick();
    bus.core_done = 4'b1010; bus.core_found = 4'b1010;
    tick();
    total++;
    if (bus.success_state !== 4'b0010 || bus.cycle_count !== 32'd4) $display("FAIL tie_1_3 got succ=%b cnt=%0d want 0010/4", bus.success_state, bus.cycle_count);
    else passed++;
  endtask

  task automatic test_all_fail();
    bus.core_done = 4'b0; bus.core_found = 4'b0;
    launch();
    bus.core_done = 4'b0001;
    tick(); tick();
    bus.core_done = 4'b0011;
    tick();
    bus.core_done = 4'b0111;
    tick();
    total++;
    if (bus.search_done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL partial_done got done=%b busy=%b want 0/1", bus.search_done, bus.busy);
    else passed++;
    bus.core_done = 4'b1111;
    tick();
    total++;
    if (bus.search_fail !== 1'b1 || bus.search_done !== 1'b1 || bus.core_stop !== 1'b1 || bus.success_state !== 4'b0000 || bus.cycle_count !== 32'd5) $display("FAIL all_fail got fail=%b done=%b stop=%b succ=%b cnt=%0d want 1/1/1/0000/5", bus.search_fail, bus.search_done, bus.core_stop, bus.success_state, bus.cycle_count);
    else passed++;
  endtask

  task automatic test_stale_done();
    bus.core_done = 4'b1111; bus.core_found = 4'b0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.search_fail !== 1'b0 || bus.search_done !== 1'b0) $display("FAIL stale_launch got fail=%b done=%b want 0/0", bus.search_fail, bus.search_done);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.search_done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL stale_arm got done=%b busy=%b want 0/1", bus.search_done, bus.busy);
    else passed++;
    tick();
    total++;
    if (bus.success_state !== 4'b0001 || bus.search_done !== 1'b1 || bus.cycle_count !== 32'd1) $display("FAIL stale_first_search got succ=%b done=%b cnt=%0d want 0001/1/1", bus.success_state, bus.search_done, bus.cycle_count);
    else passed++;
    // Stale done withdrawn while in ARM: must not conclude.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.core_done = 4'b0; bus.core_found = 4'b0;
    tick(); tick(); tick();
    total++;
    if (bus.search_done !== 1'b0 || bus.busy !== 1'b1 || bus.cycle_count !== 32'd2) $display("FAIL stale_cleared got done=%b busy=%b cnt=%0d want 0/1/2", bus.search_done, bus.busy, bus.cycle_count);
    else passed++;
    bus.core_done = 4'b1000; bus.core_found = 4'b1000;
    tick();
    total++;
    if (bus.success_state !== 4'b1000 || bus.cycle_count !== 32'd3) $display("FAIL hit3 got succ=%b cnt=%0d want 1000/3", bus.success_state, bus.cycle_count);
    else passed++;
  endtask

  task automatic test_timeout();
    bus.core_done = 4'b0; bus.core_found = 4'b0;
    launch();
    repeat (19) tick();
    total++;
    if (bus.search_done !== 1'b0 || bus.cycle_count !== 32'd19) $display("FAIL pre_timeout got done=%b cnt=%0d want 0/19", bus.search_done, bus.cycle_count);
    else passed++;
    tick();
    total++;
    if (bus.search_fail !== 1'b1 || bus.search_done !== 1'b1 || bus.core_stop !== 1'b1 || bus.success_state !== 4'b0000 || bus.busy !== 1'b0 || bus.cycle_count !== 32'd20) $display("FAIL timeout got fail=%b done=%b stop=%b succ=%b busy=%b cnt=%0d want 1/1/1/0000/0/20", bus.search_fail, bus.search_done, bus.core_stop, bus.success_state, bus.busy, bus.cycle_count);
    else passed++;
  endtask

  task automatic test_async_reset();
    launch();
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.core_start, bus.core_stop, bus.success_state, bus.search_done, bus.search_fail, bus.busy} !== 12'h000 || bus.cycle_count !== 32'd0) $display("FAIL async_reset got %h cnt=%0d want 000/0", {bus.core_start, bus.core_stop, bus.success_state, bus.search_done, bus.search_fail, bus.busy}, bus.cycle_count);
    else passed++;
    bus.start = 1'b1;
    tick();
    total++;
    if (bus.core_start !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL start_in_reset got start=%b busy=%b want 0000/0", bus.core_start, bus.busy);
    else passed++;
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.core_start !== 4'b0000) $display("FAIL post_reset_idle got busy=%b start=%b want 0/0000", bus.busy, bus.core_start);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_single_hit();
    test_simultaneous();
    test_all_fail();
    test_stale_done();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
